// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types for the multi-cycle load/store unit.
// Holds funct3 size codes, FSM states and size decode helpers.
package lsu_pkg;

    typedef enum logic [2:0] {
        SZ_B   = 3'b000,
        SZ_H   = 3'b001,
        SZ_W   = 3'b010,
        SZ_D   = 3'b011,
        SZ_BU  = 3'b100,
        SZ_HU  = 3'b101,
        SZ_WU  = 3'b110,
        SZ_RSV = 3'b111
    } size_e;

    typedef enum logic [2:0] {
        IDLE,
        REQ1,
        RESP1,
        REQ2,
        RESP2,
        DONE
    } state_e;

    // Access width in bytes: 1, 2, 4 or 8 from the low two funct3 bits.
    function automatic logic [3:0] size_bytes(size_e s);
        return 4'd1 << s[1:0];
    endfunction

    // Doubleword and unsigned-word forms exist only on a 64-bit datapath.
    function automatic logic size_legal(size_e s, int data_w);
        if (s == SZ_RSV)
            return 1'b0;
        if (data_w == 32 && (s == SZ_D || s == SZ_WU))
            return 1'b0;
        return 1'b1;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane placement for stores and extraction for loads.
// Ports: off_i/size_i select lanes; wdata_i -> wdata/mask lo+hi; beat0/1 -> rdata_o.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int BYTES = DATA_W / 8,
    localparam int OFF_W = $clog2(BYTES)
) (
    input  logic [OFF_W-1:0]  off_i,
    input  size_e             size_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] beat0_i,
    input  logic [DATA_W-1:0] beat1_i,
    output logic [DATA_W-1:0] wdata_lo_o,
    output logic [DATA_W-1:0] wdata_hi_o,
    output logic [BYTES-1:0]  mask_lo_o,
    output logic [BYTES-1:0]  mask_hi_o,
    output logic [DATA_W-1:0] rdata_o
);

    logic [3:0]          nb;
    logic [2*DATA_W-1:0] wvec;
    logic [2*BYTES-1:0]  base;
    logic [2*BYTES-1:0]  mask;
    logic [DATA_W-1:0]   rlow;
    logic                sbit;

    assign nb = size_bytes(size_i);

    // Store: the double-width vector spans both beats of a split access.
    assign wvec = {{DATA_W{1'b0}}, wdata_i} << {off_i, 3'b000};

    always_comb begin
        base = '0;
        for (int i = 0; i < 2 * BYTES; i++)
            base[i] = (i < int'(nb));
    end

    assign mask = base << off_i;

    assign {wdata_hi_o, wdata_lo_o} = wvec;
    assign {mask_hi_o, mask_lo_o}   = mask;

    // Load: bytes of a word-crossing access land contiguously after the shift.
    assign rlow = DATA_W'({beat1_i, beat0_i} >> {off_i, 3'b000});

    always_comb begin
        unique case (size_i[1:0])
            2'b00:   sbit = rlow[7];
            2'b01:   sbit = rlow[15];
            2'b10:   sbit = rlow[31];
            default: sbit = rlow[DATA_W-1];
        endcase
        sbit = sbit & ~size_i[2];
        rdata_o = rlow;
        for (int i = 0; i < DATA_W; i++)
            if (i >= 8 * int'(nb))
                rdata_o[i] = sbit;
    end

endmodule

// File: rtl/lsu_mc.sv
// lsu_mc: multi-cycle load/store unit, core request -> word-addressed memory bus.
// Ports: core_* request/completion side, mem_* req/gnt/rvalid bus side, rst active-low.
module lsu_mc
    import lsu_pkg::*;
#(
    parameter int DATA_W           = 32,
    parameter int ADDR_W           = 32,
    parameter int MISALIGNED_SPLIT = 1,
    localparam int BYTES = DATA_W / 8,
    localparam int OFF_W = $clog2(BYTES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [2:0]        core_size,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_ready,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [BYTES-1:0]  mem_wmask,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    size_e             size_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic              err_q;
    logic              cross_q;
    logic [DATA_W-1:0] beat0_q;
    logic [DATA_W-1:0] beat1_q;

    size_e             acc_size;
    logic [OFF_W-1:0]  acc_off;
    logic [3:0]        acc_nb;
    logic              acc_cross;
    logic              acc_fault;
    logic              accept;

    logic [ADDR_W-1:0] base_addr;
    logic              beat2;
    logic [DATA_W-1:0] wd_lo;
    logic [DATA_W-1:0] wd_hi;
    logic [BYTES-1:0]  wm_lo;
    logic [BYTES-1:0]  wm_hi;
    logic [DATA_W-1:0] ld_data;

    assign acc_size  = size_e'(core_size);
    assign acc_off   = core_addr[OFF_W-1:0];
    assign acc_nb    = size_bytes(acc_size);
    assign acc_cross = (int'(acc_off) + int'(acc_nb)) > BYTES;
    assign acc_fault = !size_legal(acc_size, DATA_W)
                     || (acc_cross && MISALIGNED_SPLIT == 0);

    assign core_ready = (state_q == IDLE) || (state_q == DONE);
    assign accept     = core_req && core_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            size_q  <= SZ_B;
            we_q    <= 1'b0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            cross_q <= 1'b0;
            beat0_q <= '0;
            beat1_q <= '0;
        end else begin
            if (accept) begin
                addr_q  <= core_addr;
                size_q  <= acc_size;
                we_q    <= core_we;
                wdata_q <= core_wdata;
                err_q   <= acc_fault;
                cross_q <= acc_cross;
                beat0_q <= '0;
                beat1_q <= '0;
            end
            unique case (state_q)
                IDLE, DONE: begin
                    if (!accept)
                        state_q <= IDLE;
                    else if (acc_fault)
                        state_q <= DONE;
                    else
                        state_q <= REQ1;
                end
                REQ1: begin
                    if (mem_gnt)
                        state_q <= RESP1;
                end
                RESP1: begin
                    if (mem_rvalid) begin
                        beat0_q <= mem_rdata;
                        state_q <= cross_q ? REQ2 : DONE;
                    end
                end
                REQ2: begin
                    if (mem_gnt)
                        state_q <= RESP2;
                end
                RESP2: begin
                    if (mem_rvalid) begin
                        beat1_q <= mem_rdata;
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    lsu_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .off_i      (addr_q[OFF_W-1:0]),
        .size_i     (size_q),
        .wdata_i    (wdata_q),
        .beat0_i    (beat0_q),
        .beat1_i    (beat1_q),
        .wdata_lo_o (wd_lo),
        .wdata_hi_o (wd_hi),
        .mask_lo_o  (wm_lo),
        .mask_hi_o  (wm_hi),
        .rdata_o    (ld_data)
    );

    assign base_addr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign beat2     = (state_q == REQ2);

    // Bus fields come only from registered request state, so they hold
    // steady for as long as the memory withholds its grant.
    assign mem_req   = (state_q == REQ1) || beat2;
    assign mem_we    = mem_req && we_q;
    assign mem_addr  = !mem_req ? '0
                     : beat2 ? base_addr + ADDR_W'(BYTES)
                     : base_addr;
    assign mem_wdata = !mem_we ? '0 : (beat2 ? wd_hi : wd_lo);
    assign mem_wmask = !mem_we ? '0 : (beat2 ? wm_hi : wm_lo);

    assign core_rvalid = (state_q == DONE);
    assign core_err    = core_rvalid && err_q;
    assign core_rdata  = (core_rvalid && !err_q && !we_q) ? ld_data : '0;

endmodule

// File: tb/tb_lsu_mc.sv
// tb_lsu_mc: scoreboard bench for lsu_mc with a scripted memory responder.
// Expected completions and bus beats are queued at issue and checked by monitors.
module tb_lsu_mc;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } bus_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        core_req = 1'b0;
    logic        core_req_ns = 1'b0;
    logic        core_we = 1'b0;
    logic [31:0] core_addr = '0;
    logic [2:0]  core_size = '0;
    logic [31:0] core_wdata = '0;

    logic        core_ready, core_rvalid, core_err;
    logic [31:0] core_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    logic        ns_ready, ns_rvalid, ns_err;
    logic [31:0] ns_rdata;
    logic        ns_mem_req, ns_mem_we;
    logic [31:0] ns_mem_addr, ns_mem_wdata;
    logic [3:0]  ns_mem_wmask;

    exp_t        exp_q[$];
    exp_t        exp0_q[$];
    bus_t        bus_q[$];
    logic [31:0] rd_q[$];
    exp_t        me;
    exp_t        me0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int stall = 0;
    int spurious = 0;
    bit hold_rv = 1'b0;
    bit pend = 1'b0;
    bit pend_we = 1'b0;
    string tag = "reset";

    lsu_mc #(
        .DATA_W(32), .ADDR_W(32), .MISALIGNED_SPLIT(1)
    ) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we),
        .core_addr(core_addr), .core_size(core_size),
        .core_wdata(core_wdata), .core_ready(core_ready),
        .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .core_err(core_err), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    lsu_mc #(
        .DATA_W(32), .ADDR_W(32), .MISALIGNED_SPLIT(0)
    ) dut_ns (
        .clk(clk), .rst(rst),
        .core_req(core_req_ns), .core_we(core_we),
        .core_addr(core_addr), .core_size(core_size),
        .core_wdata(core_wdata), .core_ready(ns_ready),
        .core_rvalid(ns_rvalid), .core_rdata(ns_rdata),
        .core_err(ns_err), .mem_req(ns_mem_req), .mem_we(ns_mem_we),
        .mem_addr(ns_mem_addr), .mem_wdata(ns_mem_wdata),
        .mem_wmask(ns_mem_wmask), .mem_gnt(1'b0),
        .mem_rvalid(1'b0), .mem_rdata(32'h0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s/%s: got 0x%0h, want 0x%0h",
                     tag, nm, act, expv);
        end
    endtask

    // Memory: grants after `stall` cycles, answers one cycle after grant.
    always @(negedge clk) begin
        #1;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        if (pend && !hold_rv) begin
            mem_rvalid = 1'b1;
            if (!pend_we && rd_q.size() > 0)
                mem_rdata = rd_q.pop_front();
            pend = 1'b0;
        end
        mem_gnt = 1'b0;
        if (mem_req) begin
            if (bus_q.size() == 0) begin
                chk("bus_unexpected", 1, 0);
            end else begin
                chk("bus_addr", mem_addr, bus_q[0].addr);
                chk("bus_we", mem_we, bus_q[0].we);
                if (bus_q[0].we) begin
                    chk("bus_wdata", mem_wdata, bus_q[0].wdata);
                    chk("bus_wmask", mem_wmask, bus_q[0].wmask);
                end
                if (stall > 0) begin
                    stall--;
                end else begin
                    mem_gnt = 1'b1;
                    pend    = 1'b1;
                    pend_we = mem_we;
                    bus_q.delete(0);
                end
            end
        end
    end

    // Completion monitor for both instances.
    always @(negedge clk) begin
        #2;
        if (core_rvalid) begin
            if (exp_q.size() == 0) begin
                spurious++;
                chk("rvalid_unexpected", 1, 0);
            end else begin
                me = exp_q.pop_front();
                chk("rdata", core_rdata, me.rdata);
                chk("err", core_err, me.err);
                chk("latency", cyc - me.acc, me.lat);
            end
        end
        if (ns_mem_req)
            chk("ns_mem_req", 1, 0);
        if (ns_rvalid) begin
            if (exp0_q.size() == 0) begin
                chk("ns_rvalid_unexpected", 1, 0);
            end else begin
                me0 = exp0_q.pop_front();
                chk("ns_rdata", ns_rdata, me0.rdata);
                chk("ns_err", ns_err, me0.err);
                chk("ns_latency", cyc - me0.acc, me0.lat);
            end
        end
    end

    task automatic bus(logic [31:0] a, logic w, logic [31:0] d,
                       logic [3:0] m);
        bus_t b;
        b.addr  = a;
        b.we    = w;
        b.wdata = d;
        b.wmask = m;
        bus_q.push_back(b);
    endtask

    // Called at a negedge; returns one negedge after acceptance.
    task automatic issue(bit ns, bit w, logic [31:0] a, logic [2:0] sz,
                         logic [31:0] wd, logic [31:0] erd, bit eerr,
                         int lat, bit track);
        int   t;
        exp_t e;
        t = 0;
        core_we    = w;
        core_addr  = a;
        core_size  = sz;
        core_wdata = wd;
        if (ns) core_req_ns = 1'b1;
        else    core_req    = 1'b1;
        while (!(ns ? ns_ready : core_ready) && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("accept_timeout", (t >= 50), 0);
        e.rdata = erd;
        e.err   = eerr;
        e.lat   = lat;
        e.acc   = cyc;
        if (track) begin
            if (ns) exp0_q.push_back(e);
            else    exp_q.push_back(e);
        end
        @(negedge clk);
        core_req    = 1'b0;
        core_req_ns = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() + exp0_q.size() + bus_q.size()) != 0
               && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", (t >= 100), 0);
        @(negedge clk);
    endtask

    task automatic ld1(logic [31:0] a, logic [2:0] sz,
                       logic [31:0] mrd, logic [31:0] erd);
        rd_q.push_back(mrd);
        bus({a[31:2], 2'b00}, 1'b0, 32'h0, 4'h0);
        issue(0, 0, a, sz, 32'hFFFF_FFFF, erd, 0, 3, 1);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst        = 1'b0;
        core_req   = 1'b1;
        core_we    = 1'b1;
        core_addr  = 32'h1003;
        core_size  = 3'b000;
        core_wdata = 32'h1234_56AB;
        repeat (3) @(negedge clk);
        #3;
        chk("rst_ready", core_ready, 1);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_rvalid", core_rvalid, 0);
        chk("rst_rdata", core_rdata, 0);
        chk("rst_err", core_err, 0);
        chk("rst_ns_ready", ns_ready, 1);
        @(negedge clk);
        rst = 1'b1;

        tag = "sb_1003";
        bus(32'h1000, 1'b1, 32'hAB00_0000, 4'b1000);
        issue(0, 1, 32'h1003, 3'b000, 32'h1234_56AB, 0, 0, 3, 1);
        drain();

        tag = "lh_2002";
        ld1(32'h2002, 3'b001, 32'h80FF_0000, 32'hFFFF_80FF);
        tag = "lhu_2002";
        ld1(32'h2002, 3'b101, 32'h80FF_0000, 32'h0000_80FF);
        tag = "lb_2003";
        ld1(32'h2003, 3'b000, 32'h80FF_0000, 32'hFFFF_FF80);
        tag = "lbu_2003";
        ld1(32'h2003, 3'b100, 32'h80FF_0000, 32'h0000_0080);
        tag = "lw_2000";
        ld1(32'h2000, 3'b010, 32'h80FF_0000, 32'h80FF_0000);

        tag = "split_lw";
        rd_q.push_back(32'hDDCC_0000);
        rd_q.push_back(32'h0000_FFEE);
        bus(32'h3000, 1'b0, 32'h0, 4'h0);
        bus(32'h3004, 1'b0, 32'h0, 4'h0);
        issue(0, 0, 32'h3002, 3'b010, 0, 32'hFFEE_DDCC, 0, 5, 1);
        drain();

        tag = "split_sw";
        bus(32'h3000, 1'b1, 32'h3344_0000, 4'b1100);
        bus(32'h3004, 1'b1, 32'h0000_1122, 4'b0011);
        issue(0, 1, 32'h3002, 3'b010, 32'h1122_3344, 0, 0, 5, 1);
        drain();

        tag = "split_lh";
        rd_q.push_back(32'hAA00_0000);
        rd_q.push_back(32'h0000_00BB);
        bus(32'h3000, 1'b0, 32'h0, 4'h0);
        bus(32'h3004, 1'b0, 32'h0, 4'h0);
        issue(0, 0, 32'h3003, 3'b001, 0, 32'hFFFF_BBAA, 0, 5, 1);
        drain();

        tag = "split_wrap";
        rd_q.push_back(32'h1234_0000);
        rd_q.push_back(32'h0000_5678);
        bus(32'hFFFF_FFFC, 1'b0, 32'h0, 4'h0);
        bus(32'h0000_0000, 1'b0, 32'h0, 4'h0);
        issue(0, 0, 32'hFFFF_FFFE, 3'b010, 0, 32'h5678_1234, 0, 5, 1);
        drain();

        tag = "size_111";
        issue(0, 0, 32'h2000, 3'b111, 0, 0, 1, 1, 1);
        drain();
        tag = "ld_on_32";
        issue(0, 0, 32'h2000, 3'b011, 0, 0, 1, 1, 1);
        drain();
        tag = "sw_size_111";
        issue(0, 1, 32'h2000, 3'b111, 32'hFFFF_FFFF, 0, 1, 1, 1);
        drain();

        tag = "nosplit_fault";
        issue(1, 0, 32'h3002, 3'b010, 0, 0, 1, 1, 1);
        drain();

        tag = "stall_sh";
        stall = 4;
        bus(32'h4000, 1'b1, 32'hBEEF_0000, 4'b1100);
        issue(0, 1, 32'h4002, 3'b001, 32'h1234_BEEF, 0, 0, 7, 1);
        drain();

        tag = "b2b";
        rd_q.push_back(32'h80FF_0000);
        rd_q.push_back(32'h80FF_0000);
        bus(32'h2000, 1'b0, 32'h0, 4'h0);
        bus(32'h2000, 1'b0, 32'h0, 4'h0);
        issue(0, 0, 32'h2003, 3'b100, 0, 32'h0000_0080, 0, 3, 1);
        issue(0, 0, 32'h2002, 3'b101, 0, 32'h0000_80FF, 0, 3, 1);
        drain();

        tag = "rst_resp1";
        hold_rv = 1'b1;
        rd_q.push_back(32'h0BAD_0BAD);
        bus(32'h5000, 1'b0, 32'h0, 4'h0);
        issue(0, 0, 32'h5000, 3'b010, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("rst_mid_ready", core_ready, 1);
        chk("rst_mid_mem_req", mem_req, 0);
        chk("rst_mid_rvalid", core_rvalid, 0);
        @(negedge clk);
        rst = 1'b1;
        hold_rv = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_spurious", spurious, 0);
        chk("rst_rd_consumed", rd_q.size(), 0);

        tag = "post_rst_lw";
        ld1(32'h2000, 3'b010, 32'h1234_5678, 32'h1234_5678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
